lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum WAIT cycles before an access is aborted with out_err.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid/in_ready  input/output  1/1  request handshake from execute stage.
REQ-005 in_is_load, in_is_store  input  1 each  access type.
REQ-006 in_funct3  input  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 in_addr, in_wdata  input  32 each  effective byte address; store data in low bits.
REQ-008 in_rd  input  5  destination register tag.
REQ-009 mem_req_valid/mem_req_ready  output/input  1/1  memory request handshake.
REQ-010 mem_req_wen  output  1  1 = store.
REQ-011 mem_req_addr  output  32  word address, in_addr with bits [1:0] cleared.
REQ-012 mem_req_wdata  output  32  lane-replicated store data.
REQ-013 mem_req_wmask  output  4  byte-lane enables; 0 for loads.
REQ-014 mem_resp_valid, mem_resp_rdata  input  1, 32  memory response; rdata is the full aligned word.
REQ-015 out_valid/out_ready  output/input  1/1  result handshake to writeback.
REQ-016 out_data  output  32  extended load data; 0 for stores and errors.
REQ-017 out_rd, out_wen, out_err  output  5, 1, 1  tag; register-write enable (load without error only); error flag.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; in_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, in_valid=1 SHALL latch all in_* fields; next state is REQ, or RESP directly when the request is erroneous or has neither type flag set.
REQ-020 Erroneous means: both flags set, funct3 not among the five codes (110 and 111 are invalid for any type; 100 and 101 are invalid for stores), h/hu with addr[0]=1, or w with addr[1:0]!=0. Erroneous requests give out_err=1, out_wen=0, and no memory access.
REQ-021 Neither flag set SHALL complete as a no-op with out_err=0, out_wen=0, out_data=0.
REQ-022 In REQ, mem_req_valid=1 and all mem_req_* SHALL stay stable until mem_req_ready=1; next state is WAIT.
REQ-023 Store lanes: sb wmask=0001<<addr[1:0], wdata={4{d[7:0]}}; sh wmask=0011<<addr[1:0], wdata={2{d[15:0]}}; sw wmask=1111, wdata=d.
REQ-024 In WAIT, mem_resp_valid=1 SHALL capture the result and move to RESP; mem_resp_valid is ignored in every other state.
REQ-025 Load extension SHALL select the byte or halfword at addr[1:0] of rdata; b/h sign-extend, bu/hu zero-extend, w passes the word through.
REQ-026 A WAIT counter SHALL start at 0 on entry; at count==TIMEOUT with no response, go to RESP with out_err=1; a response in that same cycle wins.
REQ-027 In RESP, out_valid=1 with stable outputs until out_ready=1; next state is IDLE. No new request is accepted in that cycle.
REQ-028 Minimum latency: accept in cycle 0, request in cycle 1, response earliest in cycle 2, out_valid in cycle 3.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear the WAIT counter and latched fields, and drive every output to 0 except in_ready, which is 1 after release.
REQ-030 Reset during REQ/WAIT SHALL abandon the access; a late mem_resp_valid SHALL be ignored.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, the funct3 width constants, and the counter-width function of TIMEOUT.
REQ-032 Sub-module lsu_load_align SHALL do the combinational lane select and extension (rdata, addr[1:0], funct3 -> data).

Verification
REQ-033 lb at 0x80000003, rdata=0x80FF_0000 -> mem_req_addr=0x80000000, out_data=0xFFFFFF80, out_wen=1.
REQ-034 sh d=0x1234ABCD at 0x80000006 -> wmask=1100, wdata=0xABCDABCD, out_wen=0, out_err=0.
REQ-035 lw at 0x80000002 -> no mem_req_valid, out_err=1 in cycle 1; mem_req_ready held 0 for 5 cycles -> request stays stable.
REQ-036 TIMEOUT=4 with no response -> out_err=1 exactly 5 WAIT cycles after entry; mem_resp_valid during IDLE is ignored.
REQ-037 rst asserted in WAIT, response arrives the next cycle -> no out_valid, in_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// Holds the FSM state encoding, RV32 width codes and the WAIT counter sizing helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bits needed to count 0..timeout inclusive, never less than one.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and extension.
// Picks the byte/halfword addressed by addr_lo out of the aligned word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_s   = byte_sel;
    half_s   = half_sel;
    case (funct3)
      F3_B:    data = 32'(byte_s);
      F3_H:    data = 32'(half_s);
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access from execute, drives a single
// memory transaction, and returns an extended result (or error) to writeback.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_err
);

  localparam int              CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [4:0]       rd_q;
  logic [31:0]      load_data;

  // Only meaningful for requests that carry at least one type flag.
  function automatic logic req_err(input logic       ld,
                                   input logic       st,
                                   input logic [2:0] f3,
                                   input logic [1:0] a);
    logic e;
    e = ld & st;
    case (f3)
      F3_B, F3_BU: e = e;
      F3_H, F3_HU: e = e | a[0];
      F3_W:        e = e | (a != 2'b00);
      default:     e = 1'b1;
    endcase
    if (st && (f3 == F3_BU || f3 == F3_HU)) e = 1'b1;
    return e;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  lsu_load_align u_align (
    .rdata   (mem_resp_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      is_load_q     <= 1'b0;
      funct3_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      rd_q          <= 5'd0;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 4'd0;
      out_valid     <= 1'b0;
      out_data      <= 32'd0;
      out_rd        <= 5'd0;
      out_wen       <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            is_load_q <= in_is_load;
            funct3_q  <= in_funct3;
            addr_lo_q <= in_addr[1:0];
            rd_q      <= in_rd;
            in_ready  <= 1'b0;
            if (!in_is_load && !in_is_store) begin
              state     <= ST_RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_wen   <= 1'b0;
              out_data  <= 32'd0;
              out_rd    <= in_rd;
            end else if (req_err(in_is_load, in_is_store, in_funct3, in_addr[1:0])) begin
              state     <= ST_RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_wen   <= 1'b0;
              out_data  <= 32'd0;
              out_rd    <= in_rd;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_req_wen   <= in_is_store;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wdata <= in_is_store ? store_data(in_funct3, in_wdata) : 32'd0;
              mem_req_wmask <= in_is_store ? store_mask(in_funct3, in_addr[1:0]) : 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        ST_WAIT: begin
          // A response in the timeout cycle still completes normally.
          if (mem_resp_valid) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_wen   <= is_load_q;
            out_data  <= is_load_q ? load_data : 32'd0;
            out_rd    <= rd_q;
          end else if (wait_cnt == CNT_MAX) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_wen   <= 1'b0;
            out_data  <= 32'd0;
            out_rd    <= rd_q;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4) with immediate-assertion checks.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; it is accepted because in_ready is 1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = a;
    in_wdata    = d;
    in_rd       = rd;
    tick();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
    tick();
    tick();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_wmask", mem_req_wmask, 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // lb at 0x80000003, minimum latency path
    mem_req_ready = 1;
    issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd7);
    chk("lb_req_valid", mem_req_valid, 1);
    chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
    chk("lb_wmask", mem_req_wmask, 4'b0000);
    chk("lb_wen", mem_req_wen, 0);
    chk("lb_in_ready", in_ready, 0);
    tick();
    chk("lb_wait_req_valid", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h80FF_0000;
    tick();
    mem_resp_valid = 0; mem_resp_rdata = 32'h0;
    chk("lb_out_valid", out_valid, 1);
    chk("lb_out_data", out_data, 32'hFFFF_FF80);
    chk("lb_out_wen", out_wen, 1);
    chk("lb_out_err", out_err, 0);
    chk("lb_out_rd", out_rd, 7);
    tick();
    chk("lb_hold_valid", out_valid, 1);
    chk("lb_hold_data", out_data, 32'hFFFF_FF80);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("lb_done_valid", out_valid, 0);
    chk("lb_done_in_ready", in_ready, 1);

    // sh 0x1234ABCD at 0x80000006
    issue(0, 1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 5'd3);
    chk("sh_wen", mem_req_wen, 1);
    chk("sh_wmask", mem_req_wmask, 4'b1100);
    chk("sh_wdata", mem_req_wdata, 32'hABCD_ABCD);
    chk("sh_addr", mem_req_addr, 32'h8000_0004);
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 0;
    chk("sh_out_valid", out_valid, 1);
    chk("sh_out_wen", out_wen, 0);
    chk("sh_out_err", out_err, 0);
    chk("sh_out_data", out_data, 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // misaligned lw: error in cycle 1, no memory request
    issue(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd9);
    chk("lwmis_req_valid", mem_req_valid, 0);
    chk("lwmis_out_valid", out_valid, 1);
    chk("lwmis_out_err", out_err, 1);
    chk("lwmis_out_wen", out_wen, 0);
    chk("lwmis_out_data", out_data, 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // lhu with memory stalling the request for 5 cycles
    mem_req_ready = 0;
    issue(1, 0, 3'b101, 32'h1000_0002, 32'h0, 5'd12);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, 32'h1000_0000);
      chk("stall_wmask", mem_req_wmask, 4'b0000);
      tick();
    end
    mem_req_ready = 1;
    tick();
    chk("stall_released", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h8001_7FFF;
    tick();
    mem_resp_valid = 0;
    chk("lhu_out_data", out_data, 32'h0000_8001);
    chk("lhu_out_rd", out_rd, 12);
    out_ready = 1;
    tick();
    out_ready = 0;

    // lh at halfword 0 sign-extends
    issue(1, 0, 3'b001, 32'h1000_0000, 32'h0, 5'd1);
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'h1234_8001;
    tick();
    mem_resp_valid = 0;
    chk("lh_out_data", out_data, 32'hFFFF_8001);
    out_ready = 1;
    tick();
    out_ready = 0;

    // lbu at byte 1 zero-extends
    issue(1, 0, 3'b100, 32'h1000_0001, 32'h0, 5'd2);
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0000_9C00;
    tick();
    mem_resp_valid = 0;
    chk("lbu_out_data", out_data, 32'h0000_009C);
    out_ready = 1;
    tick();
    out_ready = 0;

    // sb and sw lane patterns
    issue(0, 1, 3'b000, 32'h4000_0001, 32'h0000_00A5, 5'd0);
    chk("sb_wmask", mem_req_wmask, 4'b0010);
    chk("sb_wdata", mem_req_wdata, 32'hA5A5_A5A5);
    tick();
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    issue(0, 1, 3'b010, 32'h4000_0000, 32'hCAFE_F00D, 5'd0);
    chk("sw_wmask", mem_req_wmask, 4'b1111);
    chk("sw_wdata", mem_req_wdata, 32'hCAFE_F00D);
    tick();
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;

    // timeout: no response, error exactly 5 WAIT cycles after entry
    issue(1, 0, 3'b010, 32'h2000_0000, 32'h0, 5'd4);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("to_no_valid", out_valid, 0);
      tick();
    end
    chk("to_out_valid", out_valid, 1);
    chk("to_out_err", out_err, 1);
    chk("to_out_wen", out_wen, 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // response while idle is ignored
    mem_resp_valid = 1; mem_resp_rdata = 32'h1111_1111;
    tick();
    tick();
    mem_resp_valid = 0;
    chk("idle_resp_out_valid", out_valid, 0);
    chk("idle_resp_in_ready", in_ready, 1);

    // no-op, both-flags and invalid-store-width requests
    issue(0, 0, 3'b010, 32'h5000_0000, 32'h0, 5'd6);
    chk("noop_valid", out_valid, 1);
    chk("noop_err", out_err, 0);
    chk("noop_req_valid", mem_req_valid, 0);
    chk("noop_rd", out_rd, 6);
    out_ready = 1;
    tick();
    out_ready = 0;
    issue(1, 1, 3'b010, 32'h5000_0000, 32'h0, 5'd6);
    chk("both_err", out_err, 1);
    chk("both_req_valid", mem_req_valid, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    issue(0, 1, 3'b100, 32'h5000_0000, 32'h0, 5'd6);
    chk("sbu_err", out_err, 1);
    out_ready = 1;
    tick();
    out_ready = 0;

    // reset in WAIT, response arrives the next cycle
    issue(1, 0, 3'b010, 32'h3000_0004, 32'h0, 5'd8);
    tick();
    rst = 1'b1;
    #1;
    chk("rstwait_out_valid", out_valid, 0);
    chk("rstwait_req_valid", mem_req_valid, 0);
    tick();
    rst = 1'b0;
    mem_resp_valid = 1; mem_resp_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 0;
    chk("rstwait_late_valid", out_valid, 0);
    chk("rstwait_in_ready", in_ready, 1);
    tick();
    chk("rstwait_late_valid2", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
